seg_addr_seq: RTL and testbench

Parametrised segment address sequencer. Owns its own count, splits a run of TOTAL = FIRST_LEN + (NUM_SEG-1)*SEG_LEN ticks into NUM_SEG segments, and drives a registered segment address to the downstream memory/lookup stage. Adds start/abort control, one-shot or looping modes, and segment/wrap/done strobes on top of the fixed count-to-address binning. Default parameters give the legacy map: count 0..9 gives address 0, then 11-count bins for addresses 1..14, a final bin (164..174) that emits address 2, and TOTAL = 175.

---
 rtl/seg_addr_seq.sv | 173 +++++++++++++++++
 tb/tb_seg_addr_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_addr_seq.sv
// seg_addr_seq
//   Segment address sequencer. Counts a run of
//   TOTAL = FIRST_LEN + (NUM_SEG-1)*SEG_LEN ticks, splits it into NUM_SEG
//   segments and drives a registered segment address downstream. Supports
//   one-shot and looping runs, abort, and segment/wrap/done strobes.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : begin a run (accepted only in IDLE)
//   tick       : advance enable, one count step per cycle with tick=1
//   mode       : 0 = one-shot, 1 = loop; latched when start is accepted
//   abort      : terminate the run and return to IDLE
//   count      : position within the run, 0..TOTAL-1
//   addr       : current segment address (registered)
//   seg_strobe : one-cycle pulse when a segment begins (segment 0 included)
//   wrap       : one-cycle pulse on each loop-mode wrap
//   busy       : high while running
//   done       : one-cycle pulse at one-shot completion
module seg_addr_seq #(
    parameter int CNT_W     = 8,
    parameter int ADDR_W    = 4,
    parameter int FIRST_LEN = 10,
    parameter int SEG_LEN   = 11,
    parameter int NUM_SEG   = 16,
    parameter int TAIL_ADDR = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              tick,
    input  logic              mode,
    input  logic              abort,
    output logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] addr,
    output logic              seg_strobe,
    output logic              wrap,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int TOTAL = FIRST_LEN + (NUM_SEG - 1) * SEG_LEN;

    localparam logic [CNT_W-1:0]  LAST_COUNT = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0]  FIRST_END  = CNT_W'(FIRST_LEN - 1);
    localparam logic [CNT_W-1:0]  SEG_END    = CNT_W'(SEG_LEN - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_SEG - 1);
    localparam logic [ADDR_W-1:0] TAIL       = ADDR_W'(TAIL_ADDR);

    state_t            state, state_n;
    logic              mode_q, mode_n;
    logic [ADDR_W-1:0] seg_idx, seg_idx_n;
    logic [CNT_W-1:0]  seg_cnt, seg_cnt_n;
    logic [CNT_W-1:0]  count_n;
    logic [ADDR_W-1:0] addr_n;
    logic              seg_strobe_n, wrap_n, busy_n, done_n;

    // Position of the last tick of the current segment, and the index
    // the next segment will have.
    logic [CNT_W-1:0]  seg_end;
    logic [ADDR_W-1:0] idx_inc;

    assign seg_end = (seg_idx == '0) ? FIRST_END : SEG_END;
    assign idx_inc = seg_idx + ADDR_W'(1);

    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_n      = state;
        mode_n       = mode_q;
        seg_idx_n    = seg_idx;
        seg_cnt_n    = seg_cnt;
        count_n      = count;
        addr_n       = addr;
        busy_n       = busy;
        seg_strobe_n = 1'b0;
        wrap_n       = 1'b0;
        done_n       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n      = RUN;
                    mode_n       = mode;
                    seg_idx_n    = '0;
                    seg_cnt_n    = '0;
                    count_n      = '0;
                    addr_n       = '0;
                    busy_n       = 1'b1;
                    seg_strobe_n = 1'b1;
                end
            end

            RUN: begin
                if (abort) begin
                    state_n   = IDLE;
                    seg_idx_n = '0;
                    seg_cnt_n = '0;
                    count_n   = '0;
                    addr_n    = '0;
                    busy_n    = 1'b0;
                end else if (tick) begin
                    if (count == LAST_COUNT) begin
                        // End of run: the last segment ends here as well.
                        seg_idx_n = '0;
                        seg_cnt_n = '0;
                        count_n   = '0;
                        addr_n    = '0;
                        if (mode_q) begin
                            seg_strobe_n = 1'b1;
                            wrap_n       = 1'b1;
                        end else begin
                            state_n = DONE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end
                    end else begin
                        count_n = count + CNT_W'(1);
                        if (seg_cnt == seg_end) begin
                            seg_cnt_n    = '0;
                            seg_idx_n    = idx_inc;
                            addr_n       = (idx_inc == LAST_IDX) ? TAIL : idx_inc;
                            seg_strobe_n = 1'b1;
                        end else begin
                            seg_cnt_n = seg_cnt + CNT_W'(1);
                        end
                    end
                end
            end

            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end

            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            seg_idx    <= '0;
            seg_cnt    <= '0;
            count      <= '0;
            addr       <= '0;
            seg_strobe <= 1'b0;
            wrap       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            mode_q     <= mode_n;
            seg_idx    <= seg_idx_n;
            seg_cnt    <= seg_cnt_n;
            count      <= count_n;
            addr       <= addr_n;
            seg_strobe <= seg_strobe_n;
            wrap       <= wrap_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_seg_addr_seq.sv
// tb_seg_addr_seq
//   Directed bench for seg_addr_seq: default-parameter instance (legacy map)
//   plus a small-parameter instance (4 segments of 4 ticks, tail address 3).
module tb_seg_addr_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Default-parameter instance
    logic       start = 1'b0, tick = 1'b0, mode = 1'b0, abort = 1'b0;
    logic [7:0] count;
    logic [3:0] addr;
    logic       seg_strobe, wrap, busy, done;

    // Small-parameter instance
    logic       start_s = 1'b0, tick_s = 1'b0, mode_s = 1'b0, abort_s = 1'b0;
    logic [3:0] count_s;
    logic [1:0] addr_s;
    logic       seg_strobe_s, wrap_s, busy_s, done_s;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    seg_addr_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .tick       (tick),
        .mode       (mode),
        .abort      (abort),
        .count      (count),
        .addr       (addr),
        .seg_strobe (seg_strobe),
        .wrap       (wrap),
        .busy       (busy),
        .done       (done)
    );

    seg_addr_seq #(
        .CNT_W     (4),
        .ADDR_W    (2),
        .FIRST_LEN (4),
        .SEG_LEN   (4),
        .NUM_SEG   (4),
        .TAIL_ADDR (3)
    ) dut_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_s),
        .tick       (tick_s),
        .mode       (mode_s),
        .abort      (abort_s),
        .count      (count_s),
        .addr       (addr_s),
        .seg_strobe (seg_strobe_s),
        .wrap       (wrap_s),
        .busy       (busy_s),
        .done       (done_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Legacy map: 0..9 -> 0, 11-count bins for 1..14, 164..174 -> 2.
    function automatic int exp_addr(input int c);
        if (c < 10)   return 0;
        if (c >= 164) return 2;
        return (c - 10) / 11 + 1;
    endfunction

    // A segment begins when the count lands on 10, 21, 32, ...
    function automatic logic exp_seg_start(input int c);
        return (c >= 10) && (((c - 10) % 11) == 0);
    endfunction

    initial begin
        int strobes;
        int wraps;
        int n;

        // ---------------- reset state ----------------
        #12;
        check("rst_count", count, 0);
        check("rst_addr", addr, 0);
        check("rst_busy", busy, 0);
        check("rst_strobe", seg_strobe, 0);
        check("rst_wrap", wrap, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;

        // ---------------- one-shot, continuous tick ----------------
        mode  = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("os_start_busy", busy, 1);
        check("os_start_strobe", seg_strobe, 1);
        check("os_start_count", count, 0);
        check("os_start_addr", addr, 0);
        strobes = 1;
        tick = 1'b1;
        for (int i = 1; i <= 175; i++) begin
            start = (i == 31);  // start while running must be ignored
            cyc();
            if (seg_strobe) strobes++;
            if (i < 175) begin
                check("os_count", count, i);
                check("os_addr", addr, exp_addr(i));
                check("os_strobe", seg_strobe, exp_seg_start(i));
                check("os_busy", busy, 1);
                check("os_done", done, 0);
            end else begin
                check("os_end_done", done, 1);
                check("os_end_busy", busy, 0);
                check("os_end_count", count, 0);
                check("os_end_addr", addr, 0);
                check("os_end_strobe", seg_strobe, 0);
            end
        end
        start = 1'b0;
        check("os_strobe_total", strobes, 16);
        // start during the DONE cycle is ignored
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("done_start_busy", busy, 0);
        check("done_pulse_len", done, 0);
        check("done_start_strobe", seg_strobe, 0);
        cyc();
        check("idle_busy", busy, 0);

        // ---------------- loop mode, 400 ticks ----------------
        mode  = 1'b1;
        start = 1'b1;
        tick  = 1'b0;
        cyc();
        start = 1'b0;
        mode  = 1'b0;  // changing mode mid-run has no effect
        check("lp_start_busy", busy, 1);
        check("lp_start_strobe", seg_strobe, 1);
        tick  = 1'b1;
        wraps = 0;
        for (int i = 1; i <= 400; i++) begin
            cyc();
            if (wrap) wraps++;
            check("lp_wrap", wrap, (i == 175) || (i == 350));
            check("lp_count", count, i % 175);
            check("lp_addr", addr, exp_addr(i % 175));
            check("lp_strobe", seg_strobe, ((i % 175) == 0) || exp_seg_start(i % 175));
            check("lp_busy", busy, 1);
            check("lp_done", done, 0);
        end
        check("lp_wrap_total", wraps, 2);

        // ---------------- abort at count 50 together with tick ----------------
        check("ab_pre_count", count, 50);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        tick  = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_count", count, 0);
        check("ab_addr", addr, 0);
        check("ab_done", done, 0);
        check("ab_strobe", seg_strobe, 0);
        check("ab_wrap", wrap, 0);
        cyc();
        check("ab_idle_busy", busy, 0);
        check("ab_idle_done", done, 0);

        // ---------------- restart, irregular tick one-shot ----------------
        mode  = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("rs_count", count, 0);
        check("rs_busy", busy, 1);
        check("rs_strobe", seg_strobe, 1);
        n = 0;
        for (int c = 0; c < 600; c++) begin
            tick = ((c % 3) == 0);
            cyc();
            if (tick) n++;
            if (n == 175) begin
                check("irr_done", done, 1);
                check("irr_busy", busy, 0);
                check("irr_count", count, 0);
                break;
            end
            check("irr_count", count, n);
            check("irr_addr", addr, exp_addr(n));
            check("irr_strobe", seg_strobe, tick && exp_seg_start(n));
            check("irr_busy", busy, 1);
            check("irr_done", done, 0);
        end
        tick = 1'b0;
        check("irr_ticks", n, 175);
        cyc();
        check("irr_after_done", done, 0);
        check("irr_after_busy", busy, 0);

        // ---------------- asynchronous reset mid-run ----------------
        start = 1'b1;
        cyc();
        start = 1'b0;
        tick  = 1'b1;
        repeat (120) cyc();
        check("rr_pre_count", count, 120);
        check("rr_pre_addr", addr, exp_addr(120));
        tick = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;  // well before the next clock edge
        check("rr_count", count, 0);
        check("rr_addr", addr, 0);
        check("rr_busy", busy, 0);
        check("rr_strobe", seg_strobe, 0);
        check("rr_wrap", wrap, 0);
        check("rr_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("rr_restart_count", count, 0);
        check("rr_restart_busy", busy, 1);
        check("rr_restart_strobe", seg_strobe, 1);

        // ---------------- small-parameter run ----------------
        start_s = 1'b1;
        cyc();
        start_s = 1'b0;
        check("sp_start_busy", busy_s, 1);
        check("sp_start_strobe", seg_strobe_s, 1);
        check("sp_start_addr", addr_s, 0);
        tick_s = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            if (i < 16) begin
                check("sp_count", count_s, i);
                check("sp_addr", addr_s, i / 4);
                check("sp_strobe", seg_strobe_s, (i % 4) == 0);
                check("sp_done", done_s, 0);
            end else begin
                check("sp_end_done", done_s, 1);
                check("sp_end_busy", busy_s, 0);
                check("sp_end_count", count_s, 0);
                check("sp_end_addr", addr_s, 0);
                check("sp_end_wrap", wrap_s, 0);
            end
        end
        tick_s = 1'b0;
        cyc();
        check("sp_idle_done", done_s, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
